// File: rtl/report_pkg.sv
// report_pkg: shared constants for the core result reporter.
//   - Record-type codes presented on the peripheral port.
//   - Default register-report mask and record field widths.
//   - State encoding of the overflow-record FSM.
//   - Helper that decides whether a register write is reported.
package report_pkg;

   localparam int unsigned TYPE_W = 2;
   localparam int unsigned REG_W  = 5;

   localparam logic [TYPE_W-1:0] REC_RESULT = 2'b00;
   localparam logic [TYPE_W-1:0] REC_OVF    = 2'b01;

   // Default mask: x9 and x18..x25.
   localparam logic [31:0] S_REG_MASK = 32'h03FC_0200;

   // OVF_SHOW_PEND: the overflow record is on the port and another drop
   // happened meanwhile, so a fresh overflow record must follow it.
   typedef enum logic [1:0] {
      OVF_IDLE      = 2'b00,
      OVF_WAIT      = 2'b01,
      OVF_SHOW      = 2'b10,
      OVF_SHOW_PEND = 2'b11
   } ovf_state_e;

   // x0 is never reported, whatever bit 0 of the mask says.
   function automatic logic reg_selected(input logic [31:0] mask,
                                         input logic [REG_W-1:0] idx);
      return (idx != 5'd0) && mask[idx];
   endfunction

endpackage

// File: rtl/core_result_reporter_if.sv
// core_result_reporter_if: record channel from the reporter to the peripheral.
//   to_peripheral        record type (REC_RESULT / REC_OVF)
//   to_peripheral_reg    register index (0 for overflow records)
//   to_peripheral_data   register value or drop count
//   to_peripheral_valid  record presented
//   to_peripheral_ready  peripheral accepts the record
// master = reporter side, slave = peripheral side.
interface core_result_reporter_if
   import report_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [TYPE_W-1:0]     to_peripheral;
   logic [REG_W-1:0]      to_peripheral_reg;
   logic [DATA_WIDTH-1:0] to_peripheral_data;
   logic                  to_peripheral_valid;
   logic                  to_peripheral_ready;

   modport master (
      output to_peripheral, to_peripheral_reg, to_peripheral_data, to_peripheral_valid,
      input  to_peripheral_ready
   );

   modport slave (
      input  to_peripheral, to_peripheral_reg, to_peripheral_data, to_peripheral_valid,
      output to_peripheral_ready
   );

endinterface

// File: rtl/report_fifo.sv
// report_fifo: synchronous first-word-fall-through FIFO.
//   clock, reset  clock and synchronous active-high reset
//   push          write push_data (ignored when full unless popping too)
//   pop           release the head entry (ignored when empty)
//   pop_data      head entry, valid whenever empty is low
//   full, empty   occupancy flags
//   count         entries stored, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module report_fifo #(
   parameter int unsigned WIDTH = 37,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [AW:0]      count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty    = (count_r == {(AW+1){1'b0}});
   assign full     = (count_r == FULL_CNT);
   assign count    = count_r;
   assign pop_data = mem_r[rd_ptr_r];

   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge clock) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         if (do_push_s && !do_pop_s) begin
            count_r <= count_r + 1'b1;
         end else if (do_pop_s && !do_push_s) begin
            count_r <= count_r - 1'b1;
         end
      end
   end

endmodule

// File: rtl/core_result_reporter.sv
// core_result_reporter: snoops writeback register writes, buffers the ones
// selected by REG_MASK and drains them to the peripheral over valid/ready.
// Records that find the buffer full are counted, and (OVF_REPORT=1) an
// overflow record carrying the drop count follows once the buffer empties.
//   clock, reset          clock and synchronous active-high reset
//   enable                capture enable; draining continues when low
//   write/write_reg/write_data  writeback register-write bus
//   periph                record channel (master side)
//   fifo_count            records currently buffered
//   drop_count            saturating count of dropped records
module core_result_reporter
   import report_pkg::*;
#(
   parameter int unsigned CORE       = 0,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] REG_MASK   = S_REG_MASK,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned OVF_REPORT = 1,
   parameter int unsigned CNT_BITS   = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          write,
   input  logic [REG_W-1:0]              write_reg,
   input  logic [DATA_WIDTH-1:0]         write_data,
   core_result_reporter_if.master        periph,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [CNT_BITS-1:0]           drop_count
);

   localparam int unsigned RW = REG_W + DATA_WIDTH;

   logic                cap_s;
   logic                fifo_push_s;
   logic                fifo_pop_s;
   logic                drop_s;
   logic                ovf_drop_s;
   logic                ovf_ack_s;
   logic                ovf_active_s;
   logic                full_s;
   logic                empty_s;
   logic [RW-1:0]       head_s;
   logic [CNT_BITS-1:0] drop_count_r;
   logic [CNT_BITS-1:0] snap_r;
   ovf_state_e          state_r;
   ovf_state_e          state_nxt_s;

   assign cap_s        = enable && write && reg_selected(REG_MASK, write_reg);
   assign ovf_active_s = (state_r == OVF_SHOW) || (state_r == OVF_SHOW_PEND);

   // The overflow record sits in front of the FIFO head, so the FIFO only
   // drains while no overflow record is being shown.
   assign fifo_pop_s  = !ovf_active_s && !empty_s && periph.to_peripheral_ready;
   assign ovf_ack_s   = ovf_active_s && periph.to_peripheral_ready;
   assign fifo_push_s = cap_s && (!full_s || fifo_pop_s);
   assign drop_s      = cap_s && full_s && !fifo_pop_s;
   assign ovf_drop_s  = drop_s && (OVF_REPORT != 32'd0);
   assign drop_count  = drop_count_r;

   report_fifo #(
      .WIDTH (RW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push_s),
      .push_data ({write_reg, write_data}),
      .pop       (fifo_pop_s),
      .pop_data  (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (fifo_count)
   );

   // Saturating drop counter.
   always_ff @(posedge clock) begin
      if (reset) begin
         drop_count_r <= {CNT_BITS{1'b0}};
      end else if (drop_s && (drop_count_r != {CNT_BITS{1'b1}})) begin
         drop_count_r <= drop_count_r + 1'b1;
      end
   end

   // Overflow FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= OVF_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Drop count frozen when the overflow record goes on the port, so the
   // presented data stays stable while the peripheral stalls.
   always_ff @(posedge clock) begin
      if (reset) begin
         snap_r <= {CNT_BITS{1'b0}};
      end else if ((state_r == OVF_WAIT) && empty_s) begin
         snap_r <= drop_count_r;
      end
   end

   // Overflow FSM next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         OVF_IDLE: begin
            if (ovf_drop_s) begin
               state_nxt_s = OVF_WAIT;
            end else begin
               state_nxt_s = OVF_IDLE;
            end
         end
         OVF_WAIT: begin
            // An empty FIFO cannot drop, so no drop is lost on this edge.
            if (empty_s) begin
               state_nxt_s = OVF_SHOW;
            end else begin
               state_nxt_s = OVF_WAIT;
            end
         end
         OVF_SHOW: begin
            if (ovf_ack_s) begin
               state_nxt_s = ovf_drop_s ? OVF_WAIT : OVF_IDLE;
            end else begin
               state_nxt_s = ovf_drop_s ? OVF_SHOW_PEND : OVF_SHOW;
            end
         end
         OVF_SHOW_PEND: begin
            if (ovf_ack_s) begin
               state_nxt_s = OVF_WAIT;
            end else begin
               state_nxt_s = OVF_SHOW_PEND;
            end
         end
         default: begin
            state_nxt_s = OVF_IDLE;
         end
      endcase
   end

   // Record presentation: overflow record first, else the FIFO head, else 0.
   always_comb begin
      periph.to_peripheral       = REC_RESULT;
      periph.to_peripheral_reg   = {REG_W{1'b0}};
      periph.to_peripheral_data  = {DATA_WIDTH{1'b0}};
      periph.to_peripheral_valid = 1'b0;
      if (ovf_active_s) begin
         periph.to_peripheral       = REC_OVF;
         periph.to_peripheral_data  = DATA_WIDTH'(snap_r);
         periph.to_peripheral_valid = 1'b1;
      end else if (!empty_s) begin
         periph.to_peripheral       = REC_RESULT;
         periph.to_peripheral_reg   = head_s[RW-1 -: REG_W];
         periph.to_peripheral_data  = head_s[DATA_WIDTH-1:0];
         periph.to_peripheral_valid = 1'b1;
      end else begin
         periph.to_peripheral_valid = 1'b0;
      end
   end

   // Trace of every result record the peripheral accepts.
   always_ff @(posedge clock) begin
      if (!reset && fifo_pop_s) begin
         $display("core %0d: x%0d = 0x%0h", CORE, head_s[RW-1 -: REG_W],
                  head_s[DATA_WIDTH-1:0]);
      end
   end

endmodule

// File: tb/tb_core_result_reporter.sv
module tb_core_result_reporter;
   import report_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        enable;
   logic        write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [3:0]  fifo_count;
   logic [15:0] drop_count;

   int n_checks = 0;
   int n_fail   = 0;
   logic [38:0] exp_q [$];

   core_result_reporter_if #(.DATA_WIDTH(32)) periph ();

   core_result_reporter #(
      .CORE       (0),
      .DATA_WIDTH (32),
      .REG_MASK   (S_REG_MASK),
      .FIFO_DEPTH (8),
      .OVF_REPORT (1),
      .CNT_BITS   (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .write      (write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .periph     (periph),
      .fifo_count (fifo_count),
      .drop_count (drop_count)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [38:0] rec(input logic [1:0] t, input logic [4:0] r,
                                       input logic [31:0] d);
      return {t, r, d};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_write(input logic [4:0] r, input logic [31:0] d);
      write      = 1'b1;
      write_reg  = r;
      write_data = d;
      tick();
      write      = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || periph.to_peripheral_valid) && n < budget) begin
         tick();
         n++;
      end
      check("drain_in_budget", 64'(n < budget), 64'd1);
   endtask

   // Scoreboard: each handshake seen here completes on the coming edge.
   always @(negedge clock) begin
      logic [38:0] act;
      logic [38:0] exp;
      if (!reset && periph.to_peripheral_valid && periph.to_peripheral_ready) begin
         act = {periph.to_peripheral, periph.to_peripheral_reg, periph.to_peripheral_data};
         if (exp_q.size() != 0) begin
            exp = exp_q.pop_front();
         end else begin
            exp = {39{1'b1}};
         end
         check("sb_record", 64'(act), 64'(exp));
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset      = 1'b1;
      enable     = 1'b0;
      write      = 1'b0;
      write_reg  = 5'd0;
      write_data = 32'd0;
      periph.to_peripheral_ready = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", 64'(periph.to_peripheral_valid), 64'd0);
      check("rst_fields", 64'({periph.to_peripheral, periph.to_peripheral_reg,
                               periph.to_peripheral_data}), 64'd0);
      check("rst_fifo_count", 64'(fifo_count), 64'd0);
      check("rst_drop_count", 64'(drop_count), 64'd0);

      // Single result, one-cycle latency, accepted immediately.
      enable = 1'b1;
      exp_q.push_back(rec(REC_RESULT, 5'd18, 32'd5));
      do_write(5'd18, 32'd5);
      check("t1_valid", 64'(periph.to_peripheral_valid), 64'd1);
      check("t1_record", 64'({periph.to_peripheral, periph.to_peripheral_reg,
                              periph.to_peripheral_data}), 64'(rec(REC_RESULT, 5'd18, 32'd5)));
      check("t1_count_one", 64'(fifo_count), 64'd1);
      tick();
      check("t1_count_zero", 64'(fifo_count), 64'd0);
      check("t1_valid_low", 64'(periph.to_peripheral_valid), 64'd0);

      // Unselected registers and x0 are filtered out; enable gates capture.
      do_write(5'd5, 32'd7);
      do_write(5'd0, 32'd7);
      do_write(5'd26, 32'd7);
      check("t2_count", 64'(fifo_count), 64'd0);
      check("t2_valid", 64'(periph.to_peripheral_valid), 64'd0);
      check("t2_drops", 64'(drop_count), 64'd0);
      enable = 1'b0;
      do_write(5'd18, 32'd9);
      check("t2_enable_low", 64'(fifo_count), 64'd0);
      enable = 1'b1;

      // Overflow: 10 writes into 8 entries, then drain plus overflow record.
      periph.to_peripheral_ready = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         if (i <= 8) exp_q.push_back(rec(REC_RESULT, 5'd9, 32'(i)));
         do_write(5'd9, 32'(i));
      end
      check("t3_count_full", 64'(fifo_count), 64'd8);
      check("t3_drops", 64'(drop_count), 64'd2);
      exp_q.push_back(rec(REC_OVF, 5'd0, 32'd2));
      periph.to_peripheral_ready = 1'b1;
      wait_drain(40);
      check("t3_count_after", 64'(fifo_count), 64'd0);

      // Full FIFO with simultaneous pop and push over three pointer wraps.
      periph.to_peripheral_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(rec(REC_RESULT, 5'd20, 32'h100 + 32'(i)));
         do_write(5'd20, 32'h100 + 32'(i));
      end
      periph.to_peripheral_ready = 1'b1;
      for (int i = 0; i < 24; i++) begin
         exp_q.push_back(rec(REC_RESULT, 5'd21, 32'h200 + 32'(i)));
         do_write(5'd21, 32'h200 + 32'(i));
         check("t4_count_full", 64'(fifo_count), 64'd8);
      end
      check("t4_no_drop", 64'(drop_count), 64'd2);
      wait_drain(40);

      // Stall stability, then reset discards the pending record.
      periph.to_peripheral_ready = 1'b0;
      do_write(5'd9, 32'h55);
      for (int i = 0; i < 5; i++) begin
         check("t5_stable", 64'({periph.to_peripheral_valid, periph.to_peripheral,
                                 periph.to_peripheral_reg, periph.to_peripheral_data}),
               64'({1'b1, rec(REC_RESULT, 5'd9, 32'h55)}));
         tick();
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check("t5_rst_valid", 64'(periph.to_peripheral_valid), 64'd0);
      check("t5_rst_count", 64'(fifo_count), 64'd0);
      check("t5_rst_drops", 64'(drop_count), 64'd0);

      // Drop counter saturation.
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(rec(REC_RESULT, 5'd25, 32'hA0 + 32'(i)));
         do_write(5'd25, 32'hA0 + 32'(i));
      end
      for (int i = 1; i <= 70000; i++) begin
         do_write(5'd25, 32'hDEAD);
         if (i == 1000) check("t6_drops_1000", 64'(drop_count), 64'd1000);
         if (i == 65535) check("t6_drops_sat", 64'(drop_count), 64'hFFFF);
         if (i == 65536) check("t6_drops_nowrap", 64'(drop_count), 64'hFFFF);
      end
      check("t6_drops_end", 64'(drop_count), 64'hFFFF);
      exp_q.push_back(rec(REC_OVF, 5'd0, 32'h0000_FFFF));
      periph.to_peripheral_ready = 1'b1;
      wait_drain(40);
      check("sb_empty", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
